// File: rtl/fare_meter_ctrl.sv
// rtl/fare_meter_ctrl.sv - taxi meter trip sequencer with BCD distance/wait fare accumulation
// Optional night distance rate is enabled by defining FARE_NIGHT_RATE_EN.
module fare_meter_ctrl #(
`ifdef FARE_NIGHT_RATE_EN
  parameter logic [15:0] NIGHT_DIST_INC_BCD = 16'h0013,
`endif
  parameter int unsigned SEC_DIV        = 50_000_000,
  parameter logic [15:0] START_FARE_BCD = 16'h0100,
  parameter int unsigned FREE_DIST      = 30,
  parameter int unsigned DIST_STEP      = 5,
  parameter logic [15:0] DIST_INC_BCD   = 16'h0010,
  parameter int unsigned STALL_SEC      = 5,
  parameter int unsigned WAIT_SEC       = 60,
  parameter logic [15:0] WAIT_INC_BCD   = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        dist_pulse,
`ifdef FARE_NIGHT_RATE_EN
  input  logic        night,
`endif
  input  logic        max,
  output logic [15:0] distance_fare_bcd,
  output logic [15:0] wait_fare_bcd,
  output logic [15:0] distance_bcd,
  output logic [1:0]  state
);

  localparam int PW  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int FW  = (FREE_DIST > 0) ? $clog2(FREE_DIST + 1) : 1;
  localparam int SW  = $clog2(DIST_STEP + 1);
  localparam int STW = $clog2(STALL_SEC + 1);
  localparam int WW  = $clog2(WAIT_SEC + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(SEC_DIV - 1);
  localparam logic [FW-1:0]  FREE_MAX   = FW'(FREE_DIST);
  localparam logic [SW-1:0]  STEP_LAST  = SW'(DIST_STEP - 1);
  localparam logic [STW-1:0] STALL_LAST = STW'(STALL_SEC - 1);
  localparam logic [WW-1:0]  WAIT_LAST  = WW'(WAIT_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]  presc_q, presc_d;
  logic [FW-1:0]  free_q,  free_d;
  logic [SW-1:0]  step_q,  step_d;
  logic [STW-1:0] stall_q, stall_d;
  logic [WW-1:0]  wait_q,  wait_d;
  logic [15:0]    dfare_q, dfare_d;
  logic [15:0]    wfare_q, wfare_d;
  logic [15:0]    dist_q,  dist_d;

  logic        tick;
  logic        stall_hit;
  logic        wait_hit;
  logic        step_hit;
  logic [15:0] step_inc;

  // Per-digit decimal add; a carry out of the top digit pins the result at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic [4:0]  dig;
    logic        carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dig = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry};
      if (dig > 5'd9) begin
        dig   = dig + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dig[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  assign tick      = ((state_q == S_RUN) || (state_q == S_WAIT)) && (presc_q == PRESC_LAST);
  assign stall_hit = (state_q == S_RUN) && tick && !dist_pulse && (stall_q == STALL_LAST);
  assign wait_hit  = (state_q == S_WAIT) && tick && (wait_q == WAIT_LAST);
  assign step_hit  = dist_pulse && (free_q == FREE_MAX) && (step_q == STEP_LAST);

`ifdef FARE_NIGHT_RATE_EN
  assign step_inc = night ? NIGHT_DIST_INC_BCD : DIST_INC_BCD;
`else
  assign step_inc = DIST_INC_BCD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (stop)           state_d = S_HOLD;
        else if (stall_hit) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop)            state_d = S_HOLD;
        else if (dist_pulse) state_d = S_RUN;
      end
      S_HOLD: if (clear) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    free_d  = free_q;
    step_d  = step_q;
    stall_d = stall_q;
    wait_d  = wait_q;
    dfare_d = dfare_q;
    wfare_d = wfare_q;
    dist_d  = dist_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          presc_d = '0;
          free_d  = '0;
          step_d  = '0;
          stall_d = '0;
          wait_d  = '0;
          dfare_d = START_FARE_BCD;
          wfare_d = '0;
          dist_d  = '0;
        end
      end
      S_HOLD: begin
        if (clear) begin
          presc_d = '0;
          free_d  = '0;
          step_d  = '0;
          stall_d = '0;
          wait_d  = '0;
          dfare_d = '0;
          wfare_d = '0;
          dist_d  = '0;
        end
      end
      default: begin
        // stop wins: a pulse or tick landing on the stop cycle is discarded
        if (!stop) begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (dist_pulse) begin
            dist_d  = bcd_add_sat(dist_q, 16'h0001);
            stall_d = '0;
            if (free_q != FREE_MAX) free_d = free_q + FW'(1);
            else                    step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
            if (step_hit && !max) dfare_d = bcd_add_sat(dfare_q, step_inc);
          end else if (tick && (state_q == S_RUN)) begin
            stall_d = stall_hit ? '0 : stall_q + STW'(1);
          end
          if (tick && (state_q == S_WAIT)) begin
            wait_d = wait_hit ? '0 : wait_q + WW'(1);
            if (wait_hit && !max) wfare_d = bcd_add_sat(wfare_q, WAIT_INC_BCD);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      free_q  <= '0;
      step_q  <= '0;
      stall_q <= '0;
      wait_q  <= '0;
      dfare_q <= '0;
      wfare_q <= '0;
      dist_q  <= '0;
    end else begin
      presc_q <= presc_d;
      free_q  <= free_d;
      step_q  <= step_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
      dfare_q <= dfare_d;
      wfare_q <= wfare_d;
      dist_q  <= dist_d;
    end
  end

  always_comb begin
    state             = state_q;
    distance_fare_bcd = dfare_q;
    wait_fare_bcd     = wfare_q;
    distance_bcd      = dist_q;
  end

endmodule

// File: tb/tb_fare_meter_ctrl.sv
// tb/tb_fare_meter_ctrl.sv - directed vector bench for fare_meter_ctrl
module tb_fare_meter_ctrl;

  typedef struct {
    logic        st;
    logic        sp;
    logic        cl;
    logic        dp;
    logic        mx;
    int          rep;
    logic [1:0]  e_state;
    logic [15:0] e_df;
    logic [15:0] e_wf;
    logic [15:0] e_d;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, stop_a = 1'b0, clear_a = 1'b0, pulse_a = 1'b0, max_a = 1'b0;
  logic start_b = 1'b0, pulse_b = 1'b0;
  logic idle_b = 1'b0;
  logic night = 1'b0;
  logic [15:0] df_a, wf_a, d_a, df_b, wf_b, d_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fare_meter_ctrl #(.SEC_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .clear(clear_a),
    .dist_pulse(pulse_a),
`ifdef FARE_NIGHT_RATE_EN
    .night(night),
`endif
    .max(max_a), .distance_fare_bcd(df_a), .wait_fare_bcd(wf_a),
    .distance_bcd(d_a), .state(st_a)
  );

  fare_meter_ctrl #(.SEC_DIV(4), .START_FARE_BCD(16'h9995), .FREE_DIST(1), .DIST_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(idle_b), .clear(idle_b),
    .dist_pulse(pulse_b),
`ifdef FARE_NIGHT_RATE_EN
    .night(idle_b),
`endif
    .max(idle_b), .distance_fare_bcd(df_b), .wait_fare_bcd(wf_b),
    .distance_bcd(d_b), .state(st_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] es, input logic [15:0] edf,
                         input logic [15:0] ewf, input logic [15:0] ed);
    chk({tag, ".state"}, {14'b0, st_a}, {14'b0, es});
    chk({tag, ".dfare"}, df_a, edf);
    chk({tag, ".wfare"}, wf_a, ewf);
    chk({tag, ".dist"},  d_a,  ed);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    for (int r = 0; r < v.rep; r++) begin
      @(negedge clk);
      start_a = v.st; stop_a = v.sp; clear_a = v.cl; pulse_a = v.dp; max_a = v.mx;
      @(posedge clk);
      #1;
      start_a = 1'b0; stop_a = 1'b0; clear_a = 1'b0; pulse_a = 1'b0; max_a = 1'b0;
    end
    check_a(tag, v.e_state, v.e_df, v.e_wf, v.e_d);
  endtask

  task automatic step_b(input logic st, input logic dp);
    @(negedge clk);
    start_b = st; pulse_b = dp;
    @(posedge clk);
    #1;
    start_b = 1'b0; pulse_b = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic cl, input logic dp,
                              input logic mx, input int rep, input logic [1:0] es,
                              input logic [15:0] edf, input logic [15:0] ewf, input logic [15:0] ed);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.dp = dp; v.mx = mx; v.rep = rep;
    v.e_state = es; v.e_df = edf; v.e_wf = ewf; v.e_d = ed;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[20];
    vec_t nv;
    bit   reached;

    vecs[0]  = mk(0,0,0,0,0,   1, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(0,1,1,1,0,   1, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    vecs[2]  = mk(1,0,0,0,0,   1, 2'b01, 16'h0100, 16'h0000, 16'h0000);
    vecs[3]  = mk(0,0,0,1,0,  35, 2'b01, 16'h0110, 16'h0000, 16'h0035);
    vecs[4]  = mk(1,0,0,0,0,   1, 2'b01, 16'h0110, 16'h0000, 16'h0035);
    vecs[5]  = mk(0,0,0,1,0,   5, 2'b01, 16'h0120, 16'h0000, 16'h0040);
    vecs[6]  = mk(0,0,0,0,0,  18, 2'b01, 16'h0120, 16'h0000, 16'h0040);
    vecs[7]  = mk(0,0,0,0,0,   1, 2'b10, 16'h0120, 16'h0000, 16'h0040);
    vecs[8]  = mk(0,0,0,0,0, 239, 2'b10, 16'h0120, 16'h0000, 16'h0040);
    vecs[9]  = mk(0,0,0,0,0,   1, 2'b10, 16'h0120, 16'h0010, 16'h0040);
    vecs[10] = mk(0,0,0,1,0,   1, 2'b01, 16'h0120, 16'h0010, 16'h0041);
    vecs[11] = mk(0,0,0,1,1,  50, 2'b01, 16'h0120, 16'h0010, 16'h0091);
    vecs[12] = mk(0,0,0,1,0,   4, 2'b01, 16'h0130, 16'h0010, 16'h0095);
    vecs[13] = mk(0,1,0,1,0,   1, 2'b11, 16'h0130, 16'h0010, 16'h0095);
    vecs[14] = mk(1,0,0,0,0,   1, 2'b11, 16'h0130, 16'h0010, 16'h0095);
    vecs[15] = mk(0,0,0,1,0,   3, 2'b11, 16'h0130, 16'h0010, 16'h0095);
    vecs[16] = mk(0,0,0,0,0,  10, 2'b11, 16'h0130, 16'h0010, 16'h0095);
    vecs[17] = mk(0,0,1,0,0,   1, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    vecs[18] = mk(1,0,0,0,0,   1, 2'b01, 16'h0100, 16'h0000, 16'h0000);
    vecs[19] = mk(0,0,0,1,0,  35, 2'b01, 16'h0110, 16'h0000, 16'h0035);

    #22;
    rst = 1'b0;
    #1;
    check_a("reset", 2'b00, 16'h0000, 16'h0000, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (st_a == 2'b10) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reach_wait", {15'b0, reached}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 2'b00, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step_b(1'b1, 1'b0);
    chk("sat.start", df_b, 16'h9995);
    step_b(1'b0, 1'b1);
    chk("sat.free", df_b, 16'h9995);
    chk("sat.dist1", d_b, 16'h0001);
    step_b(1'b0, 1'b1);
    chk("sat.clip", df_b, 16'h9999);
    step_b(1'b0, 1'b1);
    chk("sat.hold", df_b, 16'h9999);
    chk("sat.dist3", d_b, 16'h0003);
    chk("sat.state", {14'b0, st_b}, 16'h0001);

`ifdef FARE_NIGHT_RATE_EN
    night = 1'b1;
    nv = mk(1,0,0,0,0,  1, 2'b01, 16'h0100, 16'h0000, 16'h0000);
    run_vec(nv, "night.start");
    nv = mk(0,0,0,1,0, 35, 2'b01, 16'h0113, 16'h0000, 16'h0035);
    run_vec(nv, "night.35");
    night = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
